// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the 16-bit CPU: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables per state, handshakes data memory with a timeout, flags illegal encodings.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 4,
  parameter int FUNCT_W     = 4,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                branch_taken,
  output logic                illegal_op,
  output logic                mem_fault,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [1:0] PC_NEXT   = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JUMP  = OPCODE_W'(6);
  localparam logic [FUNCT_W-1:0]  FN_MAX   = FUNCT_W'(3);

  // The wait counter only ever has to reach MEM_TIMEOUT-1; with the timeout disabled it just wraps.
  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [OPCODE_W-1:0] r_op;
  logic [FUNCT_W-1:0]  r_fn;
  logic [CNT_W-1:0]    r_wait;
  logic [CNT_W-1:0]    w_wait_nxt;

  logic                w_is_load;
  logic                w_is_store;
  logic                w_is_branch;
  logic                w_uses_imm;
  logic                w_illegal;
  logic                w_taken;
  logic                w_timeout;
  logic [ALU_OP_W-1:0] w_alu_op;

  assign w_is_load   = (r_op == OP_LOAD);
  assign w_is_store  = (r_op == OP_STORE);
  assign w_is_branch = (r_op == OP_BEQ) || (r_op == OP_BNE);
  assign w_uses_imm  = w_is_load || w_is_store || (r_op == OP_ADDI);
  assign w_illegal   = (r_op > OP_JUMP) || ((r_op == OP_RTYPE) && (r_fn > FN_MAX));
  assign w_taken     = (r_op == OP_BEQ) ? zero : !zero;
  assign w_timeout   = (MEM_TIMEOUT != 0) && (r_wait == WAIT_LAST);
  assign w_alu_op    = (r_op == OP_RTYPE) ? ALU_OP_W'(r_fn)
                     : (w_is_branch ? ALU_OP_W'(1) : '0);

  assign state = r_state;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_NEXT;
    alu_op       = '0;
    alu_src      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    branch_taken = 1'b0;
    illegal_op   = 1'b0;
    mem_fault    = 1'b0;

    unique case (r_state)
      S_FETCH: begin
        // Gated by rst_n so the IR load enable is quiet while reset is held.
        ir_write = instr_valid && rst_n;
        if (instr_valid) w_state_nxt = S_DECODE;
      end

      S_DECODE: begin
        if (w_illegal) begin
          illegal_op  = 1'b1;
          pc_write    = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (r_op == OP_JUMP) begin
          pc_write    = 1'b1;
          pc_src      = PC_JUMP;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_op  = w_alu_op;
        alu_src = w_uses_imm;
        if (w_is_branch) begin
          pc_write     = 1'b1;
          pc_src       = w_taken ? PC_BRANCH : PC_NEXT;
          branch_taken = w_taken;
          w_state_nxt  = S_FETCH;
        end else if (w_is_load || w_is_store) begin
          w_wait_nxt  = '0;
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt = S_WB;
        end
      end

      S_MEM: begin
        alu_src   = 1'b1;
        mem_read  = w_is_load;
        mem_write = w_is_store;
        // A ready on the timeout cycle still completes the access normally.
        if (mem_ready) begin
          if (w_is_load) begin
            w_state_nxt = S_WB;
          end else begin
            pc_write    = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end else if (w_timeout) begin
          mem_fault   = 1'b1;
          pc_write    = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_wait_nxt = r_wait + CNT_W'(1);
        end
      end

      S_WB: begin
        reg_write   = 1'b1;
        pc_write    = 1'b1;
        mem_to_reg  = w_is_load;
        alu_op      = w_alu_op;
        alu_src     = w_uses_imm;
        w_state_nxt = S_FETCH;
      end

      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_op    <= '0;
      r_fn    <= '0;
      r_wait  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (ir_write) begin
        r_op <= opcode;
        r_fn <= funct;
      end
    end
  end

endmodule
